// File: rtl/cla_add_arbiter_if.sv
// Request/response and adder-side signals of cla_add_arbiter, bundled as one interface.
// slave = the arbiter itself; master = the clients plus the adder beside it.
interface cla_add_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32
);
  logic [NREQ-1:0]       req_valid_i;
  logic [NREQ-1:0]       req_ready_o;
  logic [NREQ*WIDTH-1:0] req_a_i;
  logic [NREQ*WIDTH-1:0] req_b_i;
  logic [NREQ-1:0]       req_carry_i;
  logic [NREQ-1:0]       rsp_valid_o;
  logic [NREQ-1:0]       rsp_ready_i;
  logic [WIDTH-1:0]      rsp_sum_o;
  logic                  rsp_carry_o;
  logic [WIDTH-1:0]      add_a_o;
  logic [WIDTH-1:0]      add_b_o;
  logic                  add_carry_o;
  logic [WIDTH-1:0]      add_sum_i;
  logic                  add_carry_i;
  logic                  busy_o;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, req_carry_i, rsp_ready_i, add_sum_i, add_carry_i,
    output req_ready_o, rsp_valid_o, rsp_sum_o, rsp_carry_o, add_a_o, add_b_o, add_carry_o,
           busy_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, req_carry_i, rsp_ready_i, add_sum_i, add_carry_i,
    input  req_ready_o, rsp_valid_o, rsp_sum_o, rsp_carry_o, add_a_o, add_b_o, add_carry_o,
           busy_o
  );
endinterface

// File: rtl/cla_add_arbiter.sv
// Round-robin arbiter sharing one fixed-latency registered adder among NREQ requesters.
// Define CLA_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module cla_add_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ADD_LAT = 2
) (
  input logic              clk_i,
  input logic              areset_i,
  cla_add_arbiter_if.slave bus
);

  localparam int unsigned PtrW = $clog2(NREQ);
  localparam int unsigned CntW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0] owner_q, owner_d;
  logic [CntW-1:0] lat_cnt_q, lat_cnt_d;
  logic [WIDTH-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
  logic            add_c_q, add_c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic            carry_q, carry_d;

  logic [PtrW-1:0] search_base;
  logic [PtrW-1:0] grant;
  logic            grant_vld;

  function automatic logic [PtrW-1:0] wrap_add(input logic [PtrW-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return PtrW'(s);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PtrW-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

`ifdef CLA_ARB_FIXED_PRIO_EN
  assign search_base = '0;
`else
  assign search_base = rr_ptr_q;
`endif

  // First asserted request at or above search_base, wrapping modulo NREQ.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!grant_vld && bus.req_valid_i[wrap_add(search_base, i)]) begin
        grant     = wrap_add(search_base, i);
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    lat_cnt_d = lat_cnt_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    add_c_d   = add_c_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    case (state_q)
      StIdle: begin
        if (grant_vld) begin
          add_a_d   = bus.req_a_i[grant*WIDTH +: WIDTH];
          add_b_d   = bus.req_b_i[grant*WIDTH +: WIDTH];
          add_c_d   = bus.req_carry_i[grant];
          owner_d   = grant;
          lat_cnt_d = CntW'(ADD_LAT - 1);
          state_d   = StWait;
        end
      end
      StWait: begin
        if (lat_cnt_q == '0) begin
          sum_d   = bus.add_sum_i;
          carry_d = bus.add_carry_i;
          state_d = StResp;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (bus.rsp_ready_i[owner_q]) begin
`ifndef CLA_ARB_FIXED_PRIO_EN
          rr_ptr_d = wrap_add(owner_q, 1);
`endif
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      lat_cnt_q <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_c_q   <= 1'b0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      lat_cnt_q <= lat_cnt_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_c_q   <= add_c_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
    end
  end

  // req_ready is combinational from req_valid, so gate it while reset is held.
  always_comb begin
    bus.req_ready_o = '0;
    if (state_q == StIdle && grant_vld && !areset_i) bus.req_ready_o = onehot(grant);
  end

  assign bus.rsp_valid_o = (state_q == StResp) ? onehot(owner_q) : '0;
  assign bus.rsp_sum_o   = sum_q;
  assign bus.rsp_carry_o = carry_q;
  assign bus.add_a_o     = add_a_q;
  assign bus.add_b_o     = add_b_q;
  assign bus.add_carry_o = add_c_q;
  assign bus.busy_o      = (state_q != StIdle);

endmodule
